// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
// Free-running round-robin scan controller for an LTC2308 8-channel 12-bit
// SPI ADC. Each frame pulses CONVST, waits out the conversion, then shifts
// 12 SCK periods. The frame reads back the previous conversion and sends the
// config for the next one. Because the ADC applies a config one frame late,
// cur_ch (being read) and next_ch (being configured) run one step apart. The
// first frame after reset is discarded because the ADC config is unknown.
module adc_scan_ctrl #(
  parameter int NUM_CH        = 8,
  parameter int SCK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 ADC_SDO,
  output logic                 ADC_CONVST,
  output logic                 ADC_SCK,
  output logic                 ADC_SDI,
  output logic [NUM_CH*12-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_valid,
  output logic                 sample_stb,
  output logic [2:0]           sample_ch,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_CONV_WAIT,
    S_SHIFT,
    S_STORE
  } state_t;

  localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
  localparam logic [15:0] SCK_RISE    = 16'(SCK_DIV - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(2 * SCK_DIV - 1);
  localparam logic [3:0]  LAST_BIT    = 4'd11;
  localparam logic [2:0]  LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [2:0]  NEXT_CH_RST = (NUM_CH > 1) ? 3'd1 : 3'd0;

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [11:0] shift_q;
  logic [2:0]  cur_ch;
  logic [2:0]  next_ch;
  logic        primed;

  // LTC2308 config word, MSB first: {S/D, O/S, S1, S0, UNI, SLP}.
  // Single-ended unipolar, channel address scrambled as the ADC expects.
  function automatic logic [5:0] cfg_word(input logic [2:0] c);
    cfg_word = {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  // SDI level for bit period idx: config in periods 0..5, zero afterwards.
  function automatic logic sdi_bit(input logic [5:0] cfg, input logic [3:0] idx);
    sdi_bit = (idx < 4'd6) ? cfg[3'd5 - idx[2:0]] : 1'b0;
  endfunction

  function automatic logic [2:0] ch_advance(input logic [2:0] c);
    ch_advance = (c == LAST_CH) ? 3'd0 : c + 3'd1;
  endfunction

  // Frame sequencer: state, pin drive, shift capture and result store.
  // NOTE: every register here is assigned with <= so all of them update
  // together from pre-edge values; a blocking = would leak new values
  // into later statements of the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      cur_ch     <= 3'd0;
      next_ch    <= NEXT_CH_RST;
      primed     <= 1'b0;
      ADC_CONVST <= 1'b0;
      ADC_SCK    <= 1'b0;
      ADC_SDI    <= 1'b0;
      // NOTE: the result bank is reset even though it acts like a small
      // memory, because the CPU can read it before any channel is stored.
      ch_data    <= '0;
      ch_valid   <= '0;
      sample_stb <= 1'b0;
      sample_ch  <= 3'd0;
      busy       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state      <= S_CONVST;
            ADC_CONVST <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
          end
        end

        S_CONVST: begin
          if (cnt == CONVST_LAST) begin
            state      <= S_CONV_WAIT;
            ADC_CONVST <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_CONV_WAIT: begin
          if (cnt == CONV_LAST) begin
            state   <= S_SHIFT;
            cnt     <= '0;
            bit_idx <= '0;
            ADC_SDI <= sdi_bit(cfg_word(next_ch), 4'd0);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_SHIFT: begin
          // Rising SCK edge: the ADC has held SDO stable since the last fall.
          if (cnt == SCK_RISE) begin
            ADC_SCK <= 1'b1;
            shift_q <= {shift_q[10:0], ADC_SDO};
          end
          if (cnt == PERIOD_LAST) begin
            ADC_SCK <= 1'b0;
            cnt     <= '0;
            if (bit_idx == LAST_BIT) begin
              state   <= S_STORE;
              ADC_SDI <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              ADC_SDI <= sdi_bit(cfg_word(next_ch), bit_idx + 4'd1);
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_STORE: begin
          if (primed) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (cur_ch == 3'(i)) begin
                ch_data[12*i +: 12] <= shift_q;
                ch_valid[i]         <= 1'b1;
              end
            end
            sample_stb <= 1'b1;
            sample_ch  <= cur_ch;
          end
          primed  <= 1'b1;
          cur_ch  <= next_ch;
          next_ch <= ch_advance(next_ch);
          if (en) begin
            state      <= S_CONVST;
            ADC_CONVST <= 1'b1;
            cnt        <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl. It runs two instances. The first uses the
// defaults and drives an LTC2308-like model that decodes the SDI config and
// returns 0x100+channel one frame later. The second uses NUM_CH=1 and
// SCK_DIV=1 and is driven by a model that always returns 0x5A3.
module tb_adc_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0: default parameters ----------------
  logic        rst0_n, en0;
  logic        sdo0 = 1'b0;
  logic        convst0, sck0, sdi0, stb0, busy0;
  logic [95:0] ch_data0;
  logic [7:0]  ch_valid0;
  logic [2:0]  sch0;

  adc_scan_ctrl #(
    .NUM_CH(8), .SCK_DIV(2), .CONVST_CYCLES(2), .CONV_CYCLES(80)
  ) dut0 (
    .clk(clk), .reset_n(rst0_n), .en(en0), .ADC_SDO(sdo0),
    .ADC_CONVST(convst0), .ADC_SCK(sck0), .ADC_SDI(sdi0),
    .ch_data(ch_data0), .ch_valid(ch_valid0), .sample_stb(stb0),
    .sample_ch(sch0), .busy(busy0)
  );

  // ---------------- DUT 1: NUM_CH=1, SCK_DIV=1 ----------------
  logic        rst1_n, en1;
  logic        sdo1 = 1'b0;
  logic        convst1, sck1, sdi1, stb1, busy1;
  logic [11:0] ch_data1;
  logic [0:0]  ch_valid1;
  logic [2:0]  sch1;

  adc_scan_ctrl #(
    .NUM_CH(1), .SCK_DIV(1), .CONVST_CYCLES(2), .CONV_CYCLES(80)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .en(en1), .ADC_SDO(sdo1),
    .ADC_CONVST(convst1), .ADC_SCK(sck1), .ADC_SDI(sdi1),
    .ch_data(ch_data1), .ch_valid(ch_valid1), .sample_stb(stb1),
    .sample_ch(sch1), .busy(busy1)
  );

  // Hand-computed config words {S/D,O/S,S1,S0,UNI,SLP} for channels 0..7.
  logic [5:0] cfg_tab [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                              6'b101010, 6'b111010, 6'b101110, 6'b111110};

  // ADC model 0: loads result at CONVST rise, shifts SDO on SCK fall,
  // captures SDI on SCK rise and applies a complete config to the next frame.
  logic [11:0] m0_word = '0;
  logic [5:0]  m0_cap  = '0;
  logic [2:0]  m0_cfg  = '0;
  bit          m0_known = 1'b0;
  int          m0_nbits = 0;
  logic [5:0]  sdi0_q [$];
  always @(posedge convst0 or posedge sck0 or negedge sck0) begin
    if (convst0) begin
      m0_word  = m0_known ? (12'h100 + 12'(m0_cfg)) : 12'hABC;
      m0_nbits = 0;
      sdo0     = m0_word[11];
    end else if (sck0) begin
      if (m0_nbits < 6) m0_cap = {m0_cap[4:0], sdi0};
      m0_nbits++;
      if (m0_nbits == 12) begin
        sdi0_q.push_back(m0_cap);
        m0_cfg   = {m0_cap[3], m0_cap[2], m0_cap[4]};
        m0_known = 1'b1;
      end
    end else begin
      m0_word = {m0_word[10:0], 1'b0};
      sdo0    = m0_word[11];
    end
  end

  // ADC model 1: constant result, SDI words captured for inspection.
  logic [11:0] m1_word = '0;
  logic [5:0]  m1_cap  = '0;
  int          m1_nbits = 0;
  logic [5:0]  sdi1_q [$];
  always @(posedge convst1 or posedge sck1 or negedge sck1) begin
    if (convst1) begin
      m1_word  = 12'h5A3;
      m1_nbits = 0;
      sdo1     = m1_word[11];
    end else if (sck1) begin
      if (m1_nbits < 6) m1_cap = {m1_cap[4:0], sdi1};
      m1_nbits++;
      if (m1_nbits == 12) sdi1_q.push_back(m1_cap);
    end else begin
      m1_word = {m1_word[10:0], 1'b0};
      sdo1    = m1_word[11];
    end
  end

  // Strobe recorders and pin-rule watchers.
  int          stb0_cyc [$];
  logic [2:0]  stb0_ch  [$];
  logic [11:0] stb0_dat [$];
  int          stb1_cyc [$];
  logic [2:0]  stb1_ch  [$];
  logic [11:0] stb1_dat [$];
  int          viol = 0;
  always @(negedge clk) begin
    if (stb0 === 1'b1) begin
      stb0_cyc.push_back(cyc);
      stb0_ch.push_back(sch0);
      stb0_dat.push_back(ch_data0[12*sch0 +: 12]);
    end
    if (stb1 === 1'b1) begin
      stb1_cyc.push_back(cyc);
      stb1_ch.push_back(sch1);
      stb1_dat.push_back(ch_data1);
    end
    if ((sck0 === 1'b1 && convst0 === 1'b1) || (sck1 === 1'b1 && convst1 === 1'b1))
      viol++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_stb0(input int n, input int budget, input string tag);
    int k = 0;
    while (stb0_ch.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, " strobe wait"}, 32'(stb0_ch.size() >= n), 32'd1);
  endtask

  initial begin
    int c_en, c1_en, w, g, p, b, base;
    logic prev;

    rst0_n = 1'b0; rst1_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst convst",   32'(convst0),   32'd0);
    check("rst sck",      32'(sck0),      32'd0);
    check("rst sdi",      32'(sdi0),      32'd0);
    check("rst ch_data",  32'(|ch_data0), 32'd0);
    check("rst ch_valid", 32'(ch_valid0), 32'd0);
    check("rst stb",      32'(stb0),      32'd0);
    check("rst sch",      32'(sch0),      32'd0);
    check("rst busy",     32'(busy0),     32'd0);
    check("rst1 busy",    32'(busy1),     32'd0);
    check("rst1 valid",   32'(ch_valid1), 32'd0);

    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (4) tick();
    check("idle busy",   32'(busy0),   32'd0);
    check("idle convst", 32'(convst0), 32'd0);

    // Enable both instances; CONVST and busy rise on the next edge.
    en0 = 1'b1; en1 = 1'b1;
    c_en = cyc; c1_en = cyc;
    tick();
    check("en convst", 32'(convst0), 32'd1);
    check("en busy",   32'(busy0),   32'd1);

    w = 0;
    while (convst0 === 1'b1 && w < 10) begin w++; tick(); end
    check("convst width", 32'(w), 32'd2);

    g = 0;
    while (sck0 !== 1'b1 && g < 200) begin g++; tick(); end
    check("convst fall to sck rise", 32'(g), 32'd82);

    p = 0; b = 0; prev = 1'b0;
    while (convst0 !== 1'b1 && b < 200) begin
      if (sck0 === 1'b1 && prev === 1'b0) p++;
      prev = sck0;
      tick();
      b++;
    end
    check("sck pulses", 32'(p), 32'd12);
    check("first frame discarded", 32'(stb0_ch.size()), 32'd0);

    // Nine stores: channels 1..7, 0, 1 (frame 0 carried channel 0 unprimed).
    wait_stb0(9, 9 * 131 + 300, "scan");
    for (int k = 0; k < 9; k++) begin
      check($sformatf("scan ch[%0d]", k),   32'(stb0_ch[k]),  32'((k + 1) % 8));
      check($sformatf("scan data[%0d]", k), 32'(stb0_dat[k]), 32'(12'h100 + 12'((k + 1) % 8)));
    end
    check("first strobe latency", 32'(stb0_cyc[0] - c_en), 32'd263);
    check("store period",         32'(stb0_cyc[1] - stb0_cyc[0]), 32'd131);
    check("ch_valid full", 32'(ch_valid0), 32'hFF);
    for (int n = 0; n < 8; n++)
      check($sformatf("ch_data[%0d]", n), 32'(ch_data0[12*n +: 12]), 32'(12'h100 + 12'(n)));
    for (int k = 0; k < 9; k++)
      check($sformatf("sdi word[%0d]", k), 32'(sdi0_q[k]), 32'(cfg_tab[(k + 1) % 8]));

    // Drop en during CONV_WAIT of the ch3 frame (started with the ch2 strobe).
    wait_stb0(10, 300, "ch2");
    check("ch2 strobe", 32'(stb0_ch[9]), 32'd2);
    repeat (10) tick();
    en0 = 1'b0;
    check("busy mid frame", 32'(busy0), 32'd1);
    wait_stb0(11, 300, "ch3");
    check("ch3 stored",   32'(stb0_ch[10]),  32'd3);
    check("ch3 data",     32'(stb0_dat[10]), 32'h103);
    check("busy after store", 32'(busy0), 32'd0);
    repeat (30) tick();
    check("stopped no strobe", 32'(stb0_ch.size()), 32'd11);
    check("stopped convst",    32'(convst0),        32'd0);

    // Re-enable: ch4 follows after exactly one frame.
    en0 = 1'b1;
    c_en = cyc;
    wait_stb0(12, 300, "resume");
    check("resume ch",      32'(stb0_ch[11]),  32'd4);
    check("resume data",    32'(stb0_dat[11]), 32'h104);
    check("resume latency", 32'(stb0_cyc[11] - c_en), 32'd132);

    // Reset mid-SHIFT.
    b = 0;
    while (sck0 !== 1'b1 && b < 300) begin b++; tick(); end
    check("reach shift", 32'(sck0), 32'd1);
    rst0_n = 1'b0;
    #1;
    check("arst convst",   32'(convst0),   32'd0);
    check("arst sck",      32'(sck0),      32'd0);
    check("arst sdi",      32'(sdi0),      32'd0);
    check("arst ch_data",  32'(|ch_data0), 32'd0);
    check("arst ch_valid", 32'(ch_valid0), 32'd0);
    check("arst stb",      32'(stb0),      32'd0);
    check("arst sch",      32'(sch0),      32'd0);
    check("arst busy",     32'(busy0),     32'd0);
    repeat (2) tick();
    rst0_n = 1'b1;
    c_en = cyc;
    base = stb0_ch.size();
    wait_stb0(base + 1, 400, "post reset");
    check("post reset ch",      32'(stb0_ch[base]),  32'd1);
    check("post reset data",    32'(stb0_dat[base]), 32'h101);
    check("post reset latency", 32'(stb0_cyc[base] - c_en), 32'd263);

    // NUM_CH=1 / SCK_DIV=1 instance has been scanning throughout.
    check("n1 strobes", 32'(stb1_ch.size() >= 3), 32'd1);
    if (stb1_ch.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("n1 ch[%0d]", k),   32'(stb1_ch[k]),  32'd0);
        check($sformatf("n1 data[%0d]", k), 32'(stb1_dat[k]), 32'h5A3);
        check($sformatf("n1 sdi[%0d]", k),  32'(sdi1_q[k]),   32'(6'b100010));
      end
      check("n1 period",  32'(stb1_cyc[1] - stb1_cyc[0]), 32'd107);
      check("n1 latency", 32'(stb1_cyc[0] - c1_en),       32'd215);
    end
    check("n1 valid", 32'(ch_valid1), 32'd1);
    check("convst/sck overlap", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
